// File: rtl/acc_sfp_array.sv
// Per-column accumulation buffer with saturating add, sticky overflow and optional ReLU/threshold on emit.
// Latency: result on out_data one cycle after the accepting edge of a last beat; buffer read is combinational.
// Backpressure: in_ready = RUN && (!out_valid || out_ready); output register holds stable while out_ready=0.
module acc_sfp_array #(
  parameter int psum_bw = 16,
  parameter int col     = 8,
  parameter int depth   = 16,
  parameter int addr_bw = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [addr_bw-1:0]       in_addr,
  input  logic [col*psum_bw-1:0]   in_data,
  input  logic                     in_first,
  input  logic                     in_last,
  input  logic                     relu_en,
  input  logic [psum_bw-1:0]       thres,
  input  logic                     clear_req,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [addr_bw-1:0]       out_addr,
  output logic [col*psum_bw-1:0]   out_data,
  output logic [col-1:0]           ovf,
  output logic                     clearing
);

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  localparam logic [psum_bw-1:0] SAT_MAX    = {1'b0, {(psum_bw-1){1'b1}}};
  localparam logic [psum_bw-1:0] SAT_MIN    = {1'b1, {(psum_bw-1){1'b0}}};
  localparam logic [addr_bw-1:0] LAST_ENTRY = addr_bw'(depth - 1);

  state_t               state;
  logic [addr_bw-1:0]   clr_cnt;
  logic                 accept;

  logic [psum_bw-1:0]        acc_mem  [col][depth];
  logic signed [psum_bw-1:0] lane_in  [col];
  logic signed [psum_bw-1:0] lane_old [col];
  logic signed [psum_bw-1:0] lane_v   [col];
  logic signed [psum_bw-1:0] lane_out [col];
  logic [col-1:0]            lane_sat;

  assign clearing = (state == ST_CLEAR);
  // Ready passes straight through from out_ready so last beats can stream at full rate.
  assign in_ready = (state == ST_RUN) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  for (genvar c = 0; c < col; c++) begin : g_lane
    // One extra bit holds the exact sum; a mismatch between the top two bits means it left the psum range.
    logic signed [psum_bw:0] sum;
    assign lane_in[c]  = in_data[psum_bw*c +: psum_bw];
    assign lane_old[c] = acc_mem[c][in_addr];
    assign sum         = {lane_old[c][psum_bw-1], lane_old[c]} + {lane_in[c][psum_bw-1], lane_in[c]};
    assign lane_sat[c] = !in_first && (sum[psum_bw] != sum[psum_bw-1]);
    assign lane_v[c]   = in_first    ? lane_in[c] :
                         lane_sat[c] ? (sum[psum_bw] ? SAT_MIN : SAT_MAX) :
                                       sum[psum_bw-1:0];
    // Threshold compare is signed; the buffer keeps lane_v, only the emitted copy is zeroed.
    assign lane_out[c] = (relu_en && (lane_v[c] <= $signed(thres))) ? '0 : lane_v[c];
  end

  // Buffer write port: the sweep zeroes one entry per cycle, otherwise accepted beats write back.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int c = 0; c < col; c++) begin
        if (state == ST_CLEAR)
          acc_mem[c][clr_cnt] <= '0;
        else if (accept)
          acc_mem[c][in_addr] <= lane_v[c];
      end
    end
  end

  // Control FSM, sticky overflow flags and the output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_CLEAR;
      clr_cnt   <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
      ovf       <= '0;
    end else begin
      case (state)
        ST_CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == LAST_ENTRY)
            state <= ST_RUN;
        end
        ST_RUN: begin
          // A beat accepted alongside clear_req is still written; the sweep starts next cycle.
          if (clear_req) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
          end
        end
        default: state <= ST_CLEAR;
      endcase

      if (state == ST_RUN && clear_req)
        ovf <= '0;
      else if (accept)
        ovf <= ovf | lane_sat;

      // A new result reloads the register even while the previous one is being consumed.
      if (accept && in_last) begin
        out_valid <= 1'b1;
        out_addr  <= in_addr;
        for (int c = 0; c < col; c++)
          out_data[psum_bw*c +: psum_bw] <= lane_out[c];
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_acc_sfp_array.sv
// Directed bench for acc_sfp_array: reset sweep, accumulation, saturation, ReLU, backpressure, clear.
// Inputs are driven and outputs sampled on the falling edge, away from the active edge.
// Each scenario task does its own inline comparisons against hand-computed values.
module tb_acc_sfp_array;

  localparam int PB = 16;
  localparam int NC = 8;
  localparam int DW = PB * NC;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    in_addr = '0;
  logic [DW-1:0] in_data = '0;
  logic          in_first = 1'b0;
  logic          in_last = 1'b0;
  logic          relu_en = 1'b0;
  logic [PB-1:0] thres = '0;
  logic          clear_req = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [3:0]    out_addr;
  logic [DW-1:0] out_data;
  logic [NC-1:0] ovf;
  logic          clearing;

  int checks = 0;
  int passes = 0;

  acc_sfp_array #(.psum_bw(PB), .col(NC), .depth(16), .addr_bw(4)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
    .in_first(in_first), .in_last(in_last), .relu_en(relu_en), .thres(thres),
    .clear_req(clear_req),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data),
    .ovf(ovf), .clearing(clearing)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] fill(input logic [PB-1:0] v);
    fill = {NC{v}};
  endfunction

  // Present one beat at the current falling edge; returns on the falling edge after it is taken.
  task automatic beat(input logic [3:0] a, input logic [DW-1:0] d, input logic f, input logic l);
    in_valid = 1'b1; in_addr = a; in_data = d; in_first = f; in_last = l;
    @(negedge clk);
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
  endtask

  task automatic test_reset;
    int n;
    logic ready_seen;
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else passes++;
    checks++; if (out_data !== '0) $display("FAIL reset_out_data: got %h want 0", out_data); else passes++;
    checks++; if (ovf !== '0) $display("FAIL reset_ovf: got %b want 0", ovf); else passes++;
    checks++; if (clearing !== 1'b1) $display("FAIL reset_clearing: got %b want 1", clearing); else passes++;
    reset = 1'b0;
    n = 0; ready_seen = 1'b0;
    while (clearing === 1'b1 && n < 100) begin
      if (in_ready !== 1'b0) ready_seen = 1'b1;
      n++;
      @(negedge clk);
    end
    checks++; if (n != 16) $display("FAIL reset_sweep_len: got %0d want 16", n); else passes++;
    checks++; if (ready_seen !== 1'b0) $display("FAIL reset_ready_in_sweep: got %b want 0", ready_seen); else passes++;
    checks++; if (in_ready !== 1'b1) $display("FAIL reset_ready_after: got %b want 1", in_ready); else passes++;
    beat(4'd3, '0, 1'b1, 1'b1);
    checks++; if (out_valid !== 1'b1) $display("FAIL zero_beat_valid: got %b want 1", out_valid); else passes++;
    checks++; if (out_addr !== 4'd3) $display("FAIL zero_beat_addr: got %0d want 3", out_addr); else passes++;
    checks++; if (out_data !== '0) $display("FAIL zero_beat_data: got %h want 0", out_data); else passes++;
  endtask

  task automatic test_accumulate;
    beat(4'd5, fill(16'd10), 1'b1, 1'b0);
    beat(4'd5, fill(16'd7), 1'b0, 1'b0);
    checks++; if (out_valid !== 1'b0) $display("FAIL acc_no_early_valid: got %b want 0", out_valid); else passes++;
    beat(4'd5, fill(16'hFFFD), 1'b0, 1'b1);
    checks++; if (out_valid !== 1'b1) $display("FAIL acc_valid: got %b want 1", out_valid); else passes++;
    checks++; if (out_data !== fill(16'd14)) $display("FAIL acc_data: got %h want %h", out_data, fill(16'd14)); else passes++;
    checks++; if (out_addr !== 4'd5) $display("FAIL acc_addr: got %0d want 5", out_addr); else passes++;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) $display("FAIL acc_single_pulse: got %b want 0", out_valid); else passes++;
  endtask

  task automatic test_saturate;
    logic [DW-1:0] d;
    logic [DW-1:0] exp_d;
    int n;
    d = '0; d[15:0] = 16'h7FF0; d[31:16] = 16'h8010;
    beat(4'd7, d, 1'b1, 1'b0);
    d = '0; d[15:0] = 16'h0020; d[31:16] = 16'hFFE0;
    beat(4'd7, d, 1'b0, 1'b1);
    exp_d = '0; exp_d[15:0] = 16'h7FFF; exp_d[31:16] = 16'h8000;
    checks++; if (out_data !== exp_d) $display("FAIL sat_data: got %h want %h", out_data, exp_d); else passes++;
    checks++; if (ovf !== 8'b0000_0011) $display("FAIL sat_ovf: got %b want 00000011", ovf); else passes++;
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    checks++; if (ovf !== '0) $display("FAIL sat_ovf_cleared: got %b want 0", ovf); else passes++;
    checks++; if (clearing !== 1'b1) $display("FAIL sat_clear_started: got %b want 1", clearing); else passes++;
    n = 0;
    while (clearing === 1'b1 && n < 100) begin n++; @(negedge clk); end
    checks++; if (n != 16) $display("FAIL sat_sweep_len: got %0d want 16", n); else passes++;
  endtask

  task automatic test_relu;
    logic [DW-1:0] d;
    logic [DW-1:0] exp_d;
    relu_en = 1'b1; thres = 16'd5;
    d = '0; d[15:0] = 16'd5; d[31:16] = 16'd6; d[47:32] = 16'hFFFC;
    beat(4'd9, d, 1'b1, 1'b1);
    exp_d = '0; exp_d[31:16] = 16'd6;
    checks++; if (out_data !== exp_d) $display("FAIL relu_data: got %h want %h", out_data, exp_d); else passes++;
    relu_en = 1'b0;
    beat(4'd9, '0, 1'b0, 1'b1);
    checks++; if (out_data !== d) $display("FAIL relu_prerelu_kept: got %h want %h", out_data, d); else passes++;
    checks++; if (out_addr !== 4'd9) $display("FAIL relu_addr: got %0d want 9", out_addr); else passes++;
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    beat(4'd2, fill(16'd1), 1'b1, 1'b1);
    checks++; if (out_valid !== 1'b1) $display("FAIL bp_valid: got %b want 1", out_valid); else passes++;
    in_valid = 1'b1; in_addr = 4'd4; in_data = fill(16'd2); in_first = 1'b1; in_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (in_ready !== 1'b0) $display("FAIL bp_ready_low: got %b want 0", in_ready); else passes++;
      @(negedge clk);
      checks++; if (out_data !== fill(16'd1) || out_addr !== 4'd2)
        $display("FAIL bp_hold: got %h/%0d want %h/2", out_data, out_addr, fill(16'd1)); else passes++;
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) $display("FAIL bp_ready_pass: got %b want 1", in_ready); else passes++;
    @(negedge clk);
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_data !== fill(16'd2) || out_addr !== 4'd4)
      $display("FAIL bp_second: got %b/%h/%0d want 1/%h/4", out_valid, out_data, out_addr, fill(16'd2)); else passes++;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) $display("FAIL bp_no_dup: got %b want 0", out_valid); else passes++;
  endtask

  task automatic test_clear_same_cycle;
    int n;
    clear_req = 1'b1;
    in_valid = 1'b1; in_addr = 4'd6; in_data = fill(16'hFFFF); in_first = 1'b1; in_last = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; clear_req = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_data !== fill(16'hFFFF) || out_addr !== 4'd6)
      $display("FAIL clr_beat_result: got %b/%h/%0d want 1/%h/6", out_valid, out_data, out_addr, fill(16'hFFFF)); else passes++;
    checks++; if (clearing !== 1'b1) $display("FAIL clr_rise: got %b want 1", clearing); else passes++;
    n = 0;
    while (clearing === 1'b1 && n < 100) begin n++; @(negedge clk); end
    checks++; if (n != 16) $display("FAIL clr_sweep_len: got %0d want 16", n); else passes++;
    for (int a = 0; a < 16; a++) begin
      beat(4'(a), '0, 1'b0, 1'b1);
      checks++; if (out_valid !== 1'b1 || out_data !== '0 || out_addr !== 4'(a))
        $display("FAIL clr_entry_%0d: got %b/%h/%0d want 1/0/%0d", a, out_valid, out_data, out_addr, a); else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_accumulate();
    test_saturate();
    test_relu();
    test_backpressure();
    test_clear_same_cycle();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, %0d/%0d so far", passes, checks);
    $fatal(1, "timeout");
  end

endmodule
